// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings used by the slave RAM: burst types, response codes
// and the only supported transfer size.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    // Only FIXED and INCR bursts of full 32-bit beats touch the memory.
    function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_4B);
    endfunction

endpackage

// File: rtl/axi4_ram_core.sv
// MEM_WORDS x 32 storage: one byte-enabled synchronous write port and one
// asynchronous read port, so a same-cycle read sees the pre-write contents.
module axi4_ram_core #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    // NOTE: storage arrays take no reset; resetting them would force a flop
    // array instead of RAM and the contents are meant to survive reset.
    always_ff @(posedge aclk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) FSMs,
// one transaction per direction at a time, SLVERR for unsupported or out-of-range beats.
module axi4_slave_ram
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int RAM_AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {2'b00, addr[ADDR_WIDTH-1:2]} < MEM_WORDS_A;
    endfunction

    // ---------------- write path ----------------
    logic [1:0]            w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [1:0]            w_burst;
    logic                  w_ok;
    logic                  w_err;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  ram_we;

    assign w_beat      = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = !in_range(w_addr) || (s_axi_wlast != w_last_beat);
    assign w_next_addr = (w_burst == BURST_INCR) ? w_addr + ADDR_WIDTH'(4) : w_addr;
    assign ram_we      = w_beat && w_ok && in_range(w_addr);

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see the new state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= BURST_FIXED;
            w_ok          <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_burst       <= s_axi_awburst;
                        w_ok          <= burst_supported(s_axi_awburst, s_axi_awsize);
                        w_err         <= !burst_supported(s_axi_awburst, s_axi_awsize);
                        w_cnt         <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        if (w_last_beat) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_cnt        <= '0;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_next_addr;
                            w_err  <= w_err || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic                  r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_load_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [1:0]            r_burst;
    logic                  r_ok;
    logic                  r_load_ok;
    logic [31:0]           ram_rdata;
    logic [31:0]           r_load_data;
    logic [1:0]            r_load_resp;

    assign r_next_addr = (r_burst == BURST_INCR) ? r_addr + ADDR_WIDTH'(4) : r_addr;

    // The beat being loaded is beat 0 from AR in idle, otherwise the next beat.
    // NOTE: each output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        r_load_addr = r_next_addr;
        r_load_ok   = r_ok;
        if (r_state == R_IDLE) begin
            r_load_addr = s_axi_araddr;
            r_load_ok   = burst_supported(s_axi_arburst, s_axi_arsize);
        end
        r_load_ok = r_load_ok && in_range(r_load_addr);
    end

    assign r_load_data = r_load_ok ? ram_rdata : 32'd0;
    assign r_load_resp = r_load_ok ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= BURST_FIXED;
            r_ok          <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_burst       <= s_axi_arburst;
                        r_ok          <= burst_supported(s_axi_arburst, s_axi_arsize);
                        r_cnt         <= '0;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= r_load_data;
                        s_axi_rresp   <= r_load_resp;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_cnt         <= '0;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt       <= r_cnt + 8'd1;
                            r_addr      <= r_next_addr;
                            s_axi_rdata <= r_load_data;
                            s_axi_rresp <= r_load_resp;
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
            endcase
        end
    end

    axi4_ram_core #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (RAM_AW)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr (w_addr[RAM_AW+1:2]),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .raddr (r_load_addr[RAM_AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/axi4_slave_ram.md
AXI4_SLAVE_RAM -- requirements
Module: axi4_slave_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 Parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 Parameter MEM_WORDS, default 1024, number of 32-bit words in the memory.
REQ-005 Port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port areset, input, 1 bit: asynchronous, active-high reset.
REQ-007 AW channel ports: s_axi_awid in ID_WIDTH; s_axi_awaddr in ADDR_WIDTH; s_axi_awlen in 8; s_axi_awsize in 3; s_axi_awburst in 2; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-008 W channel ports: s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wlast in 1; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-009 B channel ports: s_axi_bid out ID_WIDTH; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-010 AR channel ports: s_axi_arid in ID_WIDTH; s_axi_araddr in ADDR_WIDTH; s_axi_arlen in 8; s_axi_arsize in 3; s_axi_arburst in 2; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-011 R channel ports: s_axi_rid out ID_WIDTH; s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1.

Function
REQ-012 The block shall be an AXI4 responder backed by MEM_WORDS x 32 memory; word index = addr[ADDR_WIDTH-1:2].
REQ-013 Write FSM states: W_IDLE, W_DATA, W_RESP; read FSM states: R_IDLE, R_DATA; the two FSMs are fully independent.
REQ-014 W_IDLE: awready=1; on AW handshake, capture id/addr/len/burst/size and go to W_DATA.
REQ-015 W_DATA: wready=1 starting the cycle after the AW handshake; each W handshake writes the bytes enabled by wstrb and increments the beat counter.
REQ-016 Per-beat address: INCR (01) adds 4 after each beat; FIXED (00) holds the address; arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-017 The burst ends on the beat where counter == awlen: wready drops, go to W_RESP, bvalid=1 the next cycle, bid = captured awid.
REQ-018 bresp = SLVERR (10) if any of the following occurred during the burst, else OKAY (00):
- a beat's word index >= MEM_WORDS (that beat is not written);
- awburst = WRAP or reserved (no beats are written);
- awsize != 3'b010 (no beats are written);
- wlast mismatch: wlast asserted on a non-final beat, or deasserted on the final beat.
REQ-019 W_RESP: hold bvalid, bid and bresp stable until bready; on the B handshake go to W_IDLE (awready=1 the next cycle).
REQ-020 R_IDLE: arready=1; on AR handshake, capture fields and go to R_DATA; rvalid=1 the next cycle with beat-0 data.
REQ-021 R_DATA: rdata, rresp, rlast and rid shall be held stable while rvalid=1 and rready=0.
REQ-022 Each R handshake on a non-final beat loads the next beat in the same cycle, so back-to-back beats carry no bubble; address stepping follows REQ-016.
REQ-023 rlast=1 only on beat arlen; the R handshake on that beat goes to R_IDLE with rvalid=0 the next cycle.
REQ-024 A read beat that is out of range, or belongs to a burst with a WRAP/reserved burst type or size != 010, shall return rdata=0 and rresp=SLVERR; all arlen+1 beats are still returned.
REQ-025 If a read-beat load and a write to the same word occur in the same cycle, the read returns the old data (read-before-write).
REQ-026 The block shall never assert awready in W_DATA or W_RESP, nor arready in R_DATA; there is no outstanding-transaction queue.

Reset
REQ-027 While areset=1, the block shall drive:
- awready, wready, bvalid, arready, rvalid and rlast to 0;
- bid, bresp, rid, rdata and rresp to 0;
- both FSMs to their IDLE states; beat counters to 0.
REQ-028 awready and arready shall rise on the first clock edge after areset falls.
REQ-029 Memory contents are not reset.
REQ-030 A reset asserted mid-burst abandons the transaction with no partial response; beats already written remain in memory.

Structure
REQ-031 Shared package axi4_pkg shall hold the burst encodings (FIXED/INCR/WRAP), the response codes (OKAY/EXOKAY/SLVERR/DECERR) and the SIZE_4B constant.
REQ-032 A sub-module axi4_ram_core shall hold the memory: 1 write port with byte enables and 1 asynchronous read port, parameterized by MEM_WORDS.

Verification
REQ-033 Single write: AW addr 0x10, len 0, wdata 0xDEADBEEF, wstrb F, then single read of 0x10 -> bresp 00, rdata 0xDEADBEEF, rlast 1, rresp 00.
REQ-034 INCR write at 0x100, len 3, data 1..4, with bready held 0 for 5 cycles -> bvalid held stable through the stall; INCR read of 4 beats returns 1,2,3,4 with rlast on beat 4 only.
REQ-035 Byte strobes: write 0xFFFFFFFF, then 0x00000000 with wstrb 0101 -> read returns 0xFF00FF00.
REQ-036 Out of range: with MEM_WORDS=1024, read at 0x1000 len 1 -> 2 beats, each rdata 0 and rresp 10; a write there -> bresp 10.
REQ-037 R stall and collision: read 4 beats with rready toggling 1,0,0,1 -> data stable while stalled, no beats lost; a concurrent write to the word being loaded -> old value returned.
REQ-038 Mid-burst reset: assert areset during beat 2 of a len-3 write -> all outputs 0 next edge; awready=1 one cycle after release; beats 0-1 present in memory.
